mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 2:1 multiplexer datapath between two requesters (A, B).
//  Each requester presents data with a valid/ready handshake.
//  The block drives the mux select, registers the selected word, and presents it downstream
//  on a valid/ready output.
//  Sits in front of any consumer that must accept one of two datapath sources per cycle.
// PARAMETERS
//  DATAWIDTH  8  width of A/B/D data words
// PORTS
//  Clk     in   1          system clock; all state updates on rising edge
//  Rst     in   1          synchronous, active-high reset
//  AValid  in   1          requester A has a word on AData
//  AData   in   DATAWIDTH  requester A data
//  AReady  out  1          A's word is taken this cycle
//  BValid  in   1          requester B has a word on BData
//  BData   in   DATAWIDTH  requester B data
//  BReady  out  1          B's word is taken this cycle
//  Sel     out  1          mux select: 1 = A, 0 = B (combinational)
//  DOut    out  DATAWIDTH  registered output word
//  DValid  out  1          DOut holds an unconsumed word
//  DReady  in   1          downstream accepts DOut this cycle
//  Grant   out  1          side that supplied current DOut: 1 = A, 0 = B (registered)
// BEHAVIOUR
//  - One clock (Clk); reset is synchronous and active-high (Rst).
//  - Reset (Rst=1 at rising edge):
//    - state<=IDLE, DValid<=0, DOut<=0, Grant<=0.
//    - Pri<=A: A wins the first tie.
//    - AReady/BReady are forced 0 while Rst=1.
//  - States:
//    - IDLE: DValid=0.
//    - HOLD: DValid=1; DOut and Grant stable until accepted.
//  - Slot free: Free = (state==IDLE) | DReady. Downstream acceptance frees the slot in the
//    same cycle (full throughput).
//  - Grant decision (combinational, only when Free):
//    - AValid only -> pick A.
//    - BValid only -> pick B.
//    - Both valid -> pick Pri.
//    - Neither -> no pick.
//  - Handshake: AReady = Free & pick==A; BReady = Free & pick==B. Never both 1.
//  - Sel = 1 when A is picked. Otherwise Sel = 0, including when there is no pick.
//  - On a pick, at the next edge:
//    - DOut <= selected data; DValid <= 1; state <= HOLD.
//    - Grant <= picked side.
//    - Pri <= the side NOT picked.
//    Latency from accepted input to DValid: 1 cycle.
//  - Free and no pick: DValid <= 0; state <= IDLE; DOut keeps its last value.
//  - HOLD & !DReady: all registers hold. Requester valids may stay high and are not acknowledged.
//  - Pri changes only on a pick. A lone requester streaming keeps Pri pointing at the other side.
//  - Requester data is sampled only on an AReady/BReady cycle. Valid dropping without ready
//    is permitted; no state is changed.
//  - Rst asserted mid-transfer: the pending DOut word is discarded and DValid=0 next cycle.
//    The requester is not acknowledged on that cycle.
//  - Downstream rule: DValid must not drop without DReady. Guaranteed by HOLD.
// TESTING
//  1. Rst 2 cycles, no valids:
//     DValid=0, DOut=0, Grant=0, AReady=BReady=0, Sel=0.
//  2. AValid=1 AData=8'h3C, DReady=1:
//     AReady=1, Sel=1 same cycle; next cycle DOut=3C, DValid=1, Grant=1.
//  3. AValid=BValid=1 (A=11, B=22) for 4 cycles, DReady=1:
//     DOut sequence 11,22,11,22; Grant 1,0,1,0.
//  4. DReady=0 with DValid=1 for 3 cycles while both requesters valid:
//     DOut/Grant stable; AReady=BReady=0.
//     Raise DReady -> the next word is taken in that same cycle.
//  5. Only BValid for 3 cycles, then both valid:
//     three B words, then A granted first (Pri=A).
//  6. Rst pulsed while DValid=1 and DReady=0:
//     next cycle DValid=0 and Pri=A; the tie after reset goes to A.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Round-robin arbiter that shares one 2:1 data mux between requesters A and B.
//   The chosen word is registered and offered downstream on a valid/ready pair.
//   Full throughput: a downstream accept frees the output slot in the same cycle.
//
// Ports
//   Clk     rising-edge system clock
//   Rst     synchronous, active-high reset
//   AValid  requester A has a word on AData
//   AData   requester A word
//   AReady  A's word is taken this cycle
//   BValid  requester B has a word on BData
//   BData   requester B word
//   BReady  B's word is taken this cycle
//   Sel     mux select, 1 = A, 0 = B (combinational)
//   DOut    registered output word
//   DValid  DOut holds an unconsumed word
//   DReady  downstream takes DOut this cycle
//   Grant   side that supplied the current DOut, 1 = A, 0 = B
//
// state | meaning
// IDLE  | output slot empty, DValid = 0
// HOLD  | DOut/Grant hold a word not yet taken downstream, DValid = 1
module mux2_rr_arbiter #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 AValid,
  input  logic [DATAWIDTH-1:0] AData,
  output logic                 AReady,
  input  logic                 BValid,
  input  logic [DATAWIDTH-1:0] BData,
  output logic                 BReady,
  output logic                 Sel,
  output logic [DATAWIDTH-1:0] DOut,
  output logic                 DValid,
  input  logic                 DReady,
  output logic                 Grant
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  logic   pri;     // side that wins a tie: 1 = A, 0 = B
  logic   free;
  logic   pick_a;
  logic   pick_b;
  logic   take_a;
  logic   take_b;

  assign free = (state == IDLE) | DReady;

  // A lone requester always wins; a tie goes to the priority side.
  assign pick_a = AValid & (~BValid | pri);
  assign pick_b = BValid & (~AValid | ~pri);

  // Reset masks the handshakes so nothing is acknowledged on a reset cycle.
  assign take_a = ~Rst & free & pick_a;
  assign take_b = ~Rst & free & pick_b;

  assign AReady = take_a;
  assign BReady = take_b;
  assign Sel    = take_a;
  assign DValid = (state == HOLD);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      DOut  <= '0;
      Grant <= 1'b0;
      pri   <= 1'b1;
    end else if (free) begin
      if (take_a || take_b) begin
        state <= HOLD;
        DOut  <= take_a ? AData : BData;
        Grant <= take_a;
        pri   <= ~take_a;
      end else begin
        // Slot drained with nothing new; DOut keeps its last value.
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       AValid;
  logic [7:0] AData;
  logic       AReady;
  logic       BValid;
  logic [7:0] BData;
  logic       BReady;
  logic       Sel;
  logic [7:0] DOut;
  logic       DValid;
  logic       DReady;
  logic       Grant;

  int n_assert = 0;
  int n_fail   = 0;

  mux2_rr_arbiter #(.DATAWIDTH(8)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .AValid (AValid),
    .AData  (AData),
    .AReady (AReady),
    .BValid (BValid),
    .BData  (BData),
    .BReady (BReady),
    .Sel    (Sel),
    .DOut   (DOut),
    .DValid (DValid),
    .DReady (DReady),
    .Grant  (Grant)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [7:0] exp_dout [4];
  logic       exp_grant [4];
  logic       exp_ar [4];
  logic [7:0] b_words [3];

  initial begin
    exp_dout  = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_ar    = '{1'b1, 1'b0, 1'b1, 1'b0};
    b_words   = '{8'h51, 8'h52, 8'h53};

    // Reset for two cycles, no valids
    Rst = 1'b1; AValid = 1'b0; BValid = 1'b0; AData = 8'h00; BData = 8'h00; DReady = 1'b0;
    step();
    step();
    chk("rst_dvalid", DValid, 0);
    chk("rst_dout",   DOut,   0);
    chk("rst_grant",  Grant,  0);
    chk("rst_aready", AReady, 0);
    chk("rst_bready", BReady, 0);
    chk("rst_sel",    Sel,    0);
    // Handshake must stay masked while reset is held, even with a request
    AValid = 1'b1; AData = 8'hEE;
    #1;
    chk("rst_mask_aready", AReady, 0);
    chk("rst_mask_sel",    Sel,    0);
    step();
    chk("rst_mask_dvalid", DValid, 0);

    // Single A word
    Rst = 1'b0; AValid = 1'b1; AData = 8'h3C; DReady = 1'b1;
    #1;
    chk("a_aready", AReady, 1);
    chk("a_sel",    Sel,    1);
    chk("a_bready", BReady, 0);
    step();
    chk("a_dout",   DOut,   8'h3C);
    chk("a_dvalid", DValid, 1);
    chk("a_grant",  Grant,  1);

    // Reset pulse with downstream ready returns priority to A
    AValid = 1'b0; Rst = 1'b1;
    step();
    chk("rst2_dvalid", DValid, 0);
    Rst = 1'b0;

    // Both valid, alternating grants
    AValid = 1'b1; BValid = 1'b1; AData = 8'h11; BData = 8'h22; DReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_aready", AReady, exp_ar[i]);
      chk("rr_bready", BReady, !exp_ar[i]);
      step();
      chk("rr_dout",   DOut,   exp_dout[i]);
      chk("rr_grant",  Grant,  exp_grant[i]);
      chk("rr_dvalid", DValid, 1);
    end

    // Backpressure: output held, no acknowledgements
    DReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_aready", AReady, 0);
      chk("bp_bready", BReady, 0);
      chk("bp_sel",    Sel,    0);
      step();
      chk("bp_dout",   DOut,   8'h22);
      chk("bp_grant",  Grant,  0);
      chk("bp_dvalid", DValid, 1);
    end
    DReady = 1'b1;
    #1;
    chk("bp_release_aready", AReady, 1);
    chk("bp_release_bready", BReady, 0);
    step();
    chk("bp_release_dout",  DOut,  8'h11);
    chk("bp_release_grant", Grant, 1);

    // B streams alone, then a tie goes to A
    AValid = 1'b0; BValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      BData = b_words[i];
      #1;
      chk("bonly_bready", BReady, 1);
      chk("bonly_sel",    Sel,    0);
      step();
      chk("bonly_dout",  DOut,  b_words[i]);
      chk("bonly_grant", Grant, 0);
    end
    AValid = 1'b1; AData = 8'h66;
    #1;
    chk("tie_after_b_aready", AReady, 1);
    chk("tie_after_b_bready", BReady, 0);
    step();
    chk("tie_after_b_dout",  DOut,  8'h66);
    chk("tie_after_b_grant", Grant, 1);

    // Reset mid-transfer while downstream stalled; priority was B, goes back to A
    DReady = 1'b0; Rst = 1'b1; AData = 8'h77; BData = 8'h88;
    #1;
    chk("midrst_aready", AReady, 0);
    chk("midrst_bready", BReady, 0);
    step();
    chk("midrst_dvalid", DValid, 0);
    chk("midrst_dout",   DOut,   0);
    Rst = 1'b0;
    #1;
    chk("postrst_aready", AReady, 1);
    chk("postrst_bready", BReady, 0);
    step();
    chk("postrst_dout",  DOut,  8'h77);
    chk("postrst_grant", Grant, 1);

    // Drain with no requests: DValid drops, DOut keeps last word
    AValid = 1'b0; BValid = 1'b0; DReady = 1'b1;
    step();
    chk("drain_dvalid", DValid, 0);
    chk("drain_dout",   DOut,   8'h77);
    chk("drain_grant",  Grant,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
